sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Synthesisable run controller for the multicycle MIPS core: sequences CPU reset, meters the run in checkpoint periods, and detects end-of-program.
- Run ends on cycle-budget timeout, on an explicit halt address, or on PC stall.
- Sits beside `mips` in simulation and FPGA bring-up; drives the core's reset and exposes cycle, instruction and status results.

Parameters:
- RST_CYCLES, 3: cycles cpu_reset is held high after start (≥1).
- CKPT_PERIOD, 8: RUN cycles per checkpoint (≥1).
- CKPT_COUNT, 6: checkpoints before timeout; 0 = unlimited budget.
- HALT_ADDR, 32'hFFFF_FFFC: PC value that signals program end when sampled with instr_done.
- STALL_LIMIT, 16: consecutive RUN cycles of unchanged pc that signal halt; 0 = disabled.
- CW, 32: width of cycle_cnt and instr_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset of this block.
- start  in  1  level; sampled in IDLE or DONE to begin a run.
- pc  in  32  CPU program counter.
- instr_done  in  1  one-cycle strobe per retired instruction (from the core FSM).
- cpu_reset  out  1  reset to the core.
- running  out  1  high in RUN.
- checkpoint  out  1  one-cycle pulse at the end of each period.
- done  out  1  sticky, high in DONE.
- halted  out  1  sticky, run ended by halt address or stall.
- timeout  out  1  sticky, run ended by budget.
- cycle_cnt  out  CW  RUN cycles elapsed.
- instr_cnt  out  CW  instr_done strobes counted in RUN.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; cpu_reset=1.
  - running, checkpoint, done, halted, timeout = 0.
  - cycle_cnt, instr_cnt = 0.
  - All internal counters and pc_q = 0.
  - Reset asserted mid-run aborts immediately to these values.
- States: IDLE, RST_HOLD, RUN, DONE. All outputs are registered except checkpoint = running && pcnt==CKPT_PERIOD-1.
- IDLE:
  - cpu_reset=1.
  - start=1 -> RST_HOLD; clear cycle_cnt, instr_cnt and all flags; rcnt=0.
- RST_HOLD:
  - cpu_reset=1; rcnt increments each cycle.
  - When rcnt==RST_CYCLES-1 -> RUN. cpu_reset falls on the same edge, so cpu_reset is high for exactly RST_CYCLES cycles.
  - On entry to RUN: pcnt=0, kcnt=0, scnt=0, pc_q=pc.
- RUN, every cycle:
  - cycle_cnt += 1.
  - instr_cnt += instr_done.
  - pcnt wraps 0..CKPT_PERIOD-1; kcnt += 1 on wrap.
  - Counters wrap modulo 2^CW with no saturation.
- Stall detection (STALL_LIMIT≠0):
  - pc==pc_q -> scnt += 1; else scnt=0 and pc_q=pc.
  - Stall condition: pc==pc_q and scnt==STALL_LIMIT-1.
- Halt condition: (instr_done && pc==HALT_ADDR) or stall condition.
- Timeout condition: CKPT_COUNT≠0, pcnt==CKPT_PERIOD-1 and kcnt==CKPT_COUNT-1.
- Termination:
  - Halt or timeout -> DONE on that edge, with halted or timeout set accordingly.
  - If both occur in the same cycle, halted=1 and timeout=0.
  - The terminating cycle is still counted: cycle_cnt and instr_cnt include it.
- DONE:
  - done=1; cpu_reset=0 so core state stays inspectable.
  - All counters frozen; flags sticky.
  - start=1 -> RST_HOLD with counters and flags cleared as from IDLE.
- start in RST_HOLD or RUN is ignored.
- checkpoint can be high in the same cycle as the termination condition. The pulse is still emitted and counted.

Test Plan:
- Defaults, start pulse, pc incrementing by 4 every 5 cycles, instr_done every 5th cycle:
  - cpu_reset high for exactly 3 cycles after start.
  - 6 checkpoint pulses 8 cycles apart.
  - done=1, timeout=1, halted=0, cycle_cnt=48, instr_cnt=9.
- Defaults, pc frozen at 32'h0000_0010 from RUN entry -> halted=1 with cycle_cnt=16; no checkpoint on or after cycle 16.
- instr_done with pc=HALT_ADDR on RUN cycle 20 -> DONE next edge, halted=1, cycle_cnt=21.
- CKPT_PERIOD=4, CKPT_COUNT=2, halt strobe on RUN cycle 7 (the budget-expiry cycle) -> halted=1, timeout=0, cycle_cnt=8.
- reset asserted on RUN cycle 10 -> all outputs return to reset values asynchronously; cpu_reset=1 while reset is still high.
- From DONE, start again -> counters cleared, new 3-cycle cpu_reset, second run reproduces the first scenario's results. Separately, start held high during RUN has no effect.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Run controller for the multicycle MIPS core: holds the core in reset, meters the
// run in checkpoint periods and stops it on budget expiry, halt address or PC stall.
module sim_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 3,
    parameter int unsigned CKPT_PERIOD = 8,
    parameter int unsigned CKPT_COUNT  = 6,
    parameter logic [31:0] HALT_ADDR   = 32'hFFFF_FFFC,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned CW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   pc,
    input  logic          instr_done,
    output logic          cpu_reset,
    output logic          running,
    output logic          checkpoint,
    output logic          done,
    output logic          halted,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] instr_cnt
);

    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned PW = $clog2(CKPT_PERIOD + 1);
    localparam int unsigned KW = $clog2(CKPT_COUNT + 2);
    localparam int unsigned SW = $clog2(STALL_LIMIT + 2);

    localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(CKPT_PERIOD - 1);
    localparam logic [KW-1:0] K_LAST = KW'((CKPT_COUNT == 0) ? 0 : CKPT_COUNT - 1);
    localparam logic [SW-1:0] S_LAST = SW'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [RW-1:0]   rcnt, rcnt_n;
    logic [PW-1:0]   pcnt, pcnt_n;
    logic [KW-1:0]   kcnt, kcnt_n;
    logic [SW-1:0]   scnt, scnt_n;
    logic [31:0]     pc_q, pc_q_n;
    logic            cpu_reset_n, running_n, done_n, halted_n, timeout_n;
    logic [CW-1:0]   cycle_cnt_n, instr_cnt_n;

    logic            ckpt_last, pc_same, stall_c, halt_c, budget_c;

    assign checkpoint = running && ckpt_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rcnt      <= '0;
            pcnt      <= '0;
            kcnt      <= '0;
            scnt      <= '0;
            pc_q      <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state     <= state_n;
            rcnt      <= rcnt_n;
            pcnt      <= pcnt_n;
            kcnt      <= kcnt_n;
            scnt      <= scnt_n;
            pc_q      <= pc_q_n;
            cpu_reset <= cpu_reset_n;
            running   <= running_n;
            done      <= done_n;
            halted    <= halted_n;
            timeout   <= timeout_n;
            cycle_cnt <= cycle_cnt_n;
            instr_cnt <= instr_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        rcnt_n      = rcnt;
        pcnt_n      = pcnt;
        kcnt_n      = kcnt;
        scnt_n      = scnt;
        pc_q_n      = pc_q;
        cpu_reset_n = cpu_reset;
        running_n   = running;
        done_n      = done;
        halted_n    = halted;
        timeout_n   = timeout;
        cycle_cnt_n = cycle_cnt;
        instr_cnt_n = instr_cnt;

        ckpt_last = (pcnt == P_LAST);
        pc_same   = (pc == pc_q);
        stall_c   = (STALL_LIMIT != 0) && pc_same && (scnt == S_LAST);
        halt_c    = (instr_done && (pc == HALT_ADDR)) || stall_c;
        budget_c  = (CKPT_COUNT != 0) && ckpt_last && (kcnt == K_LAST);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n     = S_RST_HOLD;
                    rcnt_n      = '0;
                    cpu_reset_n = 1'b1;
                    done_n      = 1'b0;
                    halted_n    = 1'b0;
                    timeout_n   = 1'b0;
                    cycle_cnt_n = '0;
                    instr_cnt_n = '0;
                end
            end
            S_RST_HOLD: begin
                rcnt_n = rcnt + RW'(1);
                if (rcnt == R_LAST) begin
                    state_n     = S_RUN;
                    cpu_reset_n = 1'b0;
                    running_n   = 1'b1;
                    pcnt_n      = '0;
                    kcnt_n      = '0;
                    scnt_n      = '0;
                    pc_q_n      = pc;
                end
            end
            S_RUN: begin
                cycle_cnt_n = cycle_cnt + CW'(1);
                instr_cnt_n = instr_cnt + CW'(instr_done);
                if (ckpt_last) begin
                    pcnt_n = '0;
                    kcnt_n = kcnt + KW'(1);
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
                if (STALL_LIMIT != 0) begin
                    if (pc_same) begin
                        scnt_n = scnt + SW'(1);
                    end else begin
                        scnt_n = '0;
                        pc_q_n = pc;
                    end
                end
                // halt outranks a budget expiry landing on the same cycle
                if (halt_c || budget_c) begin
                    state_n   = S_DONE;
                    running_n = 1'b0;
                    done_n    = 1'b1;
                    halted_n  = halt_c;
                    timeout_n = !halt_c;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomised and directed bench for sim_run_ctrl against a sequence-level reference
// model; two instances cover the default and a short-budget configuration.
module tb_sim_run_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFC;
    localparam int MAXC  = 256;
    localparam int STALL = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] pc = '0;
    logic        instr_done = 1'b0;
    logic        start_a, start_b;

    logic        cpu_reset_a, running_a, checkpoint_a, done_a, halted_a, timeout_a;
    logic        cpu_reset_b, running_b, checkpoint_b, done_b, halted_b, timeout_b;
    logic [31:0] cycle_cnt_a, instr_cnt_a, cycle_cnt_b, instr_cnt_b;

    logic        cur_cpu_reset, cur_running, cur_checkpoint, cur_done, cur_halted, cur_timeout;
    logic [31:0] cur_cycle_cnt, cur_instr_cnt;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign cur_cpu_reset  = sel ? cpu_reset_b  : cpu_reset_a;
    assign cur_running    = sel ? running_b    : running_a;
    assign cur_checkpoint = sel ? checkpoint_b : checkpoint_a;
    assign cur_done       = sel ? done_b       : done_a;
    assign cur_halted     = sel ? halted_b     : halted_a;
    assign cur_timeout    = sel ? timeout_b    : timeout_a;
    assign cur_cycle_cnt  = sel ? cycle_cnt_b  : cycle_cnt_a;
    assign cur_instr_cnt  = sel ? instr_cnt_b  : instr_cnt_a;

    sim_run_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pc(pc), .instr_done(instr_done),
        .cpu_reset(cpu_reset_a), .running(running_a), .checkpoint(checkpoint_a),
        .done(done_a), .halted(halted_a), .timeout(timeout_a),
        .cycle_cnt(cycle_cnt_a), .instr_cnt(instr_cnt_a)
    );

    sim_run_ctrl #(.CKPT_PERIOD(4), .CKPT_COUNT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pc(pc), .instr_done(instr_done),
        .cpu_reset(cpu_reset_b), .running(running_b), .checkpoint(checkpoint_b),
        .done(done_b), .halted(halted_b), .timeout(timeout_b),
        .cycle_cnt(cycle_cnt_b), .instr_cnt(instr_cnt_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] s_pc [MAXC];
    bit          s_id [MAXC];
    bit          obs_ck [MAXC];
    logic [31:0] pc_entry;
    logic [31:0] first_cc, first_ic;
    logic [2:0]  first_flags;

    // Reference: the run ends on the first cycle that is the budget's last cycle, retires
    // an instruction at HALT, or completes STALL consecutive equal PC samples.
    function automatic void model(input int P, input int K, output int endc,
                                  output bit h, output bit to, output int ic);
        int run;
        logic [31:0] prev;
        bit ha, bu;
        run = 0; prev = pc_entry; ic = 0; endc = MAXC - 1; h = 0; to = 0;
        for (int t = 0; t < MAXC; t++) begin
            run  = (s_pc[t] == prev) ? run + 1 : 0;
            prev = s_pc[t];
            ha   = (s_id[t] && s_pc[t] == HALT) || (run >= STALL);
            bu   = (t == P * K - 1);
            ic  += int'(s_id[t]);
            if (ha || bu) begin
                endc = t; h = ha; to = !ha;
                return;
            end
        end
    endfunction

    // Starts a run on the selected instance and plays s_pc/s_id, one entry per RUN cycle.
    task automatic run_scn(input int hold, output int rst_hi, output int ncyc, output bit hung);
        rst_hi = 0; ncyc = 0; hung = 1;
        for (int t = 0; t < MAXC; t++) obs_ck[t] = 0;
        @(negedge clk);
        start = 1; pc = pc_entry; instr_done = 0;
        @(negedge clk);
        first_cc = cur_cycle_cnt; first_ic = cur_instr_cnt;
        first_flags = {cur_done, cur_halted, cur_timeout};
        if (hold == 0) start = 0;
        for (int i = 0; i < 20; i++) begin
            if (cur_running) begin hung = 0; break; end
            if (cur_cpu_reset) rst_hi++;
            @(negedge clk);
        end
        if (hung) begin start = 0; return; end
        hung = 1;
        for (int t = 0; t < MAXC; t++) begin
            if (!cur_running) begin hung = 0; break; end
            obs_ck[t] = cur_checkpoint;
            pc = s_pc[t]; instr_done = s_id[t];
            ncyc++;
            if (ncyc >= hold) start = 0;
            @(negedge clk);
        end
        instr_done = 0; start = 0;
    endtask

    task automatic load_timeout_stim();
        pc_entry = 32'h0000_0100;
        for (int t = 0; t < MAXC; t++) begin
            s_pc[t] = 32'h0000_0100 + 32'(4 * (t / 5));
            s_id[t] = ((t % 5) == 4);
        end
    endtask

    task automatic test_reset();
        sel = 0; reset = 1; start = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({cpu_reset_a, running_a, checkpoint_a, done_a, halted_a, timeout_a} !== 6'b100000) begin
            n_bad++; $display("FAIL reset.flags_a: got %b want 100000", {cpu_reset_a, running_a, checkpoint_a, done_a, halted_a, timeout_a}); end
        n_cmp++; if ({cycle_cnt_a, instr_cnt_a} !== 64'd0) begin
            n_bad++; $display("FAIL reset.counts_a: got %0d/%0d want 0/0", cycle_cnt_a, instr_cnt_a); end
        n_cmp++; if ({cpu_reset_b, running_b, checkpoint_b, done_b, halted_b, timeout_b} !== 6'b100000) begin
            n_bad++; $display("FAIL reset.flags_b: got %b want 100000", {cpu_reset_b, running_b, checkpoint_b, done_b, halted_b, timeout_b}); end
        reset = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({cpu_reset_a, running_a, done_a} !== 3'b100) begin
            n_bad++; $display("FAIL reset.idle_hold: got %b want 100", {cpu_reset_a, running_a, done_a}); end
    endtask

    // Shared by the plain, restarted and start-held runs: all must give the same result.
    task automatic test_timeout_run(input string nm, input int hold);
        int rst_hi, ncyc, ck_err, ck_n;
        bit hung;
        sel = 0;
        load_timeout_stim();
        run_scn(hold, rst_hi, ncyc, hung);
        ck_err = 0; ck_n = 0;
        for (int t = 0; t < ncyc; t++) begin
            ck_n += int'(obs_ck[t]);
            if (obs_ck[t] !== ((t % 8) == 7)) ck_err++;
        end
        n_cmp++; if (hung !== 1'b0) begin n_bad++; $display("FAIL %s.hang: got %0d want 0", nm, hung); end
        n_cmp++; if (rst_hi !== 3) begin n_bad++; $display("FAIL %s.cpu_reset_len: got %0d want 3", nm, rst_hi); end
        n_cmp++; if (first_cc !== 32'd0 || first_ic !== 32'd0 || first_flags !== 3'b000) begin
            n_bad++; $display("FAIL %s.cleared: got %0d/%0d/%b want 0/0/000", nm, first_cc, first_ic, first_flags); end
        n_cmp++; if ({cur_done, cur_halted, cur_timeout} !== 3'b101) begin
            n_bad++; $display("FAIL %s.flags: got %b want 101", nm, {cur_done, cur_halted, cur_timeout}); end
        n_cmp++; if (cur_cycle_cnt !== 32'd48) begin n_bad++; $display("FAIL %s.cycle_cnt: got %0d want 48", nm, cur_cycle_cnt); end
        n_cmp++; if (cur_instr_cnt !== 32'd9) begin n_bad++; $display("FAIL %s.instr_cnt: got %0d want 9", nm, cur_instr_cnt); end
        n_cmp++; if (ck_n !== 6 || ck_err !== 0) begin
            n_bad++; $display("FAIL %s.checkpoints: got %0d pulses %0d misplaced want 6 pulses 0 misplaced", nm, ck_n, ck_err); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({cur_done, cur_cpu_reset, cur_running, cur_checkpoint} !== 4'b1000 || cur_cycle_cnt !== 32'd48) begin
            n_bad++; $display("FAIL %s.frozen: got %b cc=%0d want 1000 cc=48", nm, {cur_done, cur_cpu_reset, cur_running, cur_checkpoint}, cur_cycle_cnt); end
    endtask

    task automatic test_stall();
        int rst_hi, ncyc, endc, eic, ck_n;
        bit hung, eh, et;
        sel = 0;
        pc_entry = 32'h0000_0010;
        for (int t = 0; t < MAXC; t++) begin
            s_pc[t] = 32'h0000_0010; s_id[t] = ($urandom_range(0, 1) == 1);
        end
        run_scn(0, rst_hi, ncyc, hung);
        model(8, 6, endc, eh, et, eic);
        ck_n = 0;
        for (int t = 0; t < ncyc; t++) ck_n += int'(obs_ck[t]);
        n_cmp++; if ({hung, cur_done, cur_halted, cur_timeout} !== 4'b0110) begin
            n_bad++; $display("FAIL stall.flags: got %b want 0110", {hung, cur_done, cur_halted, cur_timeout}); end
        n_cmp++; if (cur_cycle_cnt !== 32'd16) begin n_bad++; $display("FAIL stall.cycle_cnt: got %0d want 16", cur_cycle_cnt); end
        n_cmp++; if (cur_instr_cnt !== 32'(eic)) begin n_bad++; $display("FAIL stall.instr_cnt: got %0d want %0d", cur_instr_cnt, eic); end
        n_cmp++; if (ck_n !== 2 || obs_ck[7] !== 1'b1 || obs_ck[15] !== 1'b1) begin
            n_bad++; $display("FAIL stall.checkpoints: got %0d pulses want 2 at cycles 7,15", ck_n); end
        @(negedge clk);
        n_cmp++; if (cur_checkpoint !== 1'b0) begin n_bad++; $display("FAIL stall.ckpt_after: got %b want 0", cur_checkpoint); end
    endtask

    task automatic test_halt_addr();
        int rst_hi, ncyc, endc, eic;
        bit hung, eh, et;
        sel = 0;
        pc_entry = 32'h0000_0400;
        for (int t = 0; t < MAXC; t++) begin
            s_pc[t] = 32'h0000_0404 + 32'(4 * t); s_id[t] = ($urandom_range(0, 2) == 0);
        end
        s_pc[20] = HALT; s_id[20] = 1;
        run_scn(0, rst_hi, ncyc, hung);
        model(8, 6, endc, eh, et, eic);
        n_cmp++; if ({hung, cur_done, cur_halted, cur_timeout} !== 4'b0110) begin
            n_bad++; $display("FAIL halt_addr.flags: got %b want 0110", {hung, cur_done, cur_halted, cur_timeout}); end
        n_cmp++; if (cur_cycle_cnt !== 32'd21) begin n_bad++; $display("FAIL halt_addr.cycle_cnt: got %0d want 21", cur_cycle_cnt); end
        n_cmp++; if (cur_instr_cnt !== 32'(eic)) begin n_bad++; $display("FAIL halt_addr.instr_cnt: got %0d want %0d", cur_instr_cnt, eic); end
    endtask

    task automatic test_both();
        int rst_hi, ncyc, ck_n;
        bit hung;
        sel = 1;
        pc_entry = 32'h0000_0800;
        for (int t = 0; t < MAXC; t++) begin
            s_pc[t] = 32'h0000_0804 + 32'(4 * t); s_id[t] = 0;
        end
        s_pc[7] = HALT; s_id[7] = 1;
        run_scn(0, rst_hi, ncyc, hung);
        ck_n = 0;
        for (int t = 0; t < ncyc; t++) ck_n += int'(obs_ck[t]);
        n_cmp++; if ({hung, cur_done, cur_halted, cur_timeout} !== 4'b0110) begin
            n_bad++; $display("FAIL both.flags: got %b want 0110", {hung, cur_done, cur_halted, cur_timeout}); end
        n_cmp++; if (cur_cycle_cnt !== 32'd8 || cur_instr_cnt !== 32'd1) begin
            n_bad++; $display("FAIL both.counts: got %0d/%0d want 8/1", cur_cycle_cnt, cur_instr_cnt); end
        n_cmp++; if (ck_n !== 2 || obs_ck[3] !== 1'b1 || obs_ck[7] !== 1'b1) begin
            n_bad++; $display("FAIL both.checkpoints: got %0d pulses want 2 at cycles 3,7", ck_n); end
        sel = 0;
    endtask

    task automatic test_abort();
        bit seen;
        sel = 0; seen = 0;
        @(negedge clk);
        start = 1; pc = 32'h0000_2000;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 20; i++) begin
            if (running_a) begin seen = 1; break; end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL abort.enter_run: got %0d want 1", seen); end
        for (int t = 0; t < 10; t++) begin
            pc = 32'h0000_2004 + 32'(4 * t); instr_done = t[0];
            @(negedge clk);
        end
        instr_done = 0;
        n_cmp++; if (cycle_cnt_a !== 32'd10 || instr_cnt_a !== 32'd5) begin
            n_bad++; $display("FAIL abort.pre_counts: got %0d/%0d want 10/5", cycle_cnt_a, instr_cnt_a); end
        reset = 1;
        #1;
        n_cmp++; if ({cpu_reset_a, running_a, checkpoint_a, done_a, halted_a, timeout_a} !== 6'b100000) begin
            n_bad++; $display("FAIL abort.flags: got %b want 100000", {cpu_reset_a, running_a, checkpoint_a, done_a, halted_a, timeout_a}); end
        n_cmp++; if ({cycle_cnt_a, instr_cnt_a} !== 64'd0) begin
            n_bad++; $display("FAIL abort.counts: got %0d/%0d want 0/0", cycle_cnt_a, instr_cnt_a); end
        @(negedge clk);
        n_cmp++; if (cpu_reset_a !== 1'b1 || running_a !== 1'b0) begin
            n_bad++; $display("FAIL abort.held: got %b%b want 10", cpu_reset_a, running_a); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int rst_hi, ncyc, endc, eic, P, K, len, ck_err;
        bit hung, eh, et;
        logic [31:0] v;
        for (int it = 0; it < 24; it++) begin
            sel = ((it % 3) == 2);
            P = sel ? 4 : 8; K = sel ? 2 : 6;
            pc_entry = $urandom() & 32'h7FFF_FFFC;
            v = pc_entry; len = $urandom_range(1, 20);
            for (int t = 0; t < MAXC; t++) begin
                if (len == 0) begin
                    len = $urandom_range(1, 20);
                    v = ($urandom_range(0, 9) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFC);
                end
                s_pc[t] = v; s_id[t] = ($urandom_range(0, 3) == 0); len--;
            end
            run_scn(0, rst_hi, ncyc, hung);
            model(P, K, endc, eh, et, eic);
            ck_err = 0;
            for (int t = 0; t < ncyc; t++) if (obs_ck[t] !== ((t % P) == P - 1)) ck_err++;
            n_cmp++; if (hung !== 1'b0 || rst_hi !== 3) begin
                n_bad++; $display("FAIL random%0d.start: got hang=%0d rst=%0d want 0/3", it, hung, rst_hi); end
            n_cmp++; if ({cur_done, cur_halted, cur_timeout} !== {1'b1, eh, et}) begin
                n_bad++; $display("FAIL random%0d.flags: got %b want %b", it, {cur_done, cur_halted, cur_timeout}, {1'b1, eh, et}); end
            n_cmp++; if (cur_cycle_cnt !== 32'(endc + 1) || ncyc !== endc + 1) begin
                n_bad++; $display("FAIL random%0d.cycle_cnt: got %0d (%0d run cycles) want %0d", it, cur_cycle_cnt, ncyc, endc + 1); end
            n_cmp++; if (cur_instr_cnt !== 32'(eic)) begin
                n_bad++; $display("FAIL random%0d.instr_cnt: got %0d want %0d", it, cur_instr_cnt, eic); end
            n_cmp++; if (ck_err !== 0) begin
                n_bad++; $display("FAIL random%0d.checkpoints: got %0d misplaced want 0", it, ck_err); end
        end
        sel = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timeout_run("timeout", 0);
        test_timeout_run("restart", 0);
        test_timeout_run("hold_start", 40);
        test_stall();
        test_halt_addr();
        test_both();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
